guy_frame_ctrl: RTL
===================

# guy_frame_ctrl

Frame sequencer for the lane-runner game. It captures the 64-row obstacle stream and the start lane into a row buffer, then launches the move solver and gives it random-access reads of the buffer. It collects the solver's 63 moves into a move buffer and drains them as a gap-free 63-cycle `out_valid` burst. It sits between the chip-level pins and the solver core, and owns every protocol and latency guarantee on the output side.

## Interface
- `LAT_MAX`, default 2900: maximum number of cycles from the end of input to the first `out_valid`.
- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  high for exactly 64 consecutive cycles per frame.
- `guy`  in  3  start lane; valid on the first `in_valid` cycle only.
- `in0`..`in7`  in  2 each  obstacle code for lanes 0..7: 0 free, 1 low (jump), 2 high (walk under), 3 wall.
- `slv_start`  out  1  one-cycle pulse that launches the solver.
- `slv_pos`  out  3  registered start lane, held stable until the next frame.
- `slv_raddr`  in  6  row index requested by the solver.
- `slv_rdata`  out  16  row `{in7,...,in0}` at `slv_raddr`; combinational, same cycle.
- `slv_we`  in  1  move write strobe.
- `slv_waddr`  in  6  move index, 0..62.
- `slv_wdata`  in  2  move code: 0 stop, 1 right, 2 left, 3 jump.
- `slv_done`  in  1  one-cycle pulse: all moves written.
- `out_valid`  out  1  move burst valid.
- `out`  out  2  move code; 0 whenever `out_valid` is low.
- `err`  out  1  sticky protocol/timeout flag; cleared by `rst` or at the start of the next frame.

## Operation
- FSM states are IDLE, LOAD, SOLVE and DRAIN.
- IDLE, with `in_valid` = 1:
  - Write the row to `row_buf[0]`, latch `guy` into `slv_pos`, set `cnt` = 1.
  - Clear `err`.
  - Go to LOAD.
- LOAD:
  - Each `in_valid` cycle writes `row_buf[cnt]` and increments `cnt`.
  - The write with `cnt` = 63 goes to SOLVE and asserts `slv_start` on the next cycle.
  - If `in_valid` drops before 64 rows: set `err`, zero the unwritten rows, go to SOLVE anyway.
- SOLVE:
  - A `slv_we` writes `mv_buf[slv_waddr]`. Writes with address > 62 are dropped and set `err`.
  - `lat` counts cycles from the `slv_start` cycle.
  - `slv_done` goes to DRAIN with `cnt` = 0.
  - If `lat` reaches `LAT_MAX`: set `err` and go to DRAIN. Moves not written are 0 (stop); `mv_buf` is cleared on entry to LOAD.
- DRAIN:
  - `out_valid` = 1 and `out` = `mv_buf[cnt]`; `cnt` increments each cycle.
  - After `cnt` = 62 go to IDLE; `out_valid` and `out` are 0 the next cycle.
- `in_valid` outside IDLE/LOAD is ignored and sets `err`.
- `slv_we` or `slv_done` outside SOLVE is ignored.
- `slv_rdata` is readable in every state and reflects the latest completed row write.
- `cnt` is 6 bits and never wraps: terminal values are decoded explicitly.
- `lat` is 12 bits and saturates.

## Timing
- Reset values:
  - FSM in IDLE.
  - `out_valid`, `out`, `slv_start`, `err` = 0.
  - `slv_pos` = 0; `cnt` and `lat` = 0.
  - Buffers are not reset; `mv_buf` is cleared on entry to LOAD.
- `rst` asserted mid-frame (any state) returns to IDLE on the next edge with all outputs 0. No partial burst may continue.
- `slv_start` is asserted on the cycle after the 64th `in_valid` cycle, i.e. the first cycle `in_valid` is low.
- First `out_valid` is on the cycle after `slv_done`. Minimum latency from `in_valid` falling to `out_valid` rising is 2 cycles; maximum is `LAT_MAX` + 1.
- `out_valid` is never high while `in_valid` is high.
- `out_valid` is high for exactly 63 consecutive cycles.
- `out` is registered; `out` = 0 whenever `out_valid` = 0.
- `slv_done` in the same cycle as a `slv_we`: the write is applied before the drain starts.
- `slv_done` in the same cycle as the timeout: treated as done; `err` is not set.

## Structure
- The shared package `guy_pkg` holds:
  - the move codes MV_STOP/RIGHT/LEFT/JUMP;
  - the obstacle codes OB_FREE/LOW/HIGH/WALL;
  - the constants N_ROWS = 64, N_MOVES = 63, N_LANES = 8;
  - the FSM state enum.
- Sub-module `guy_row_buf`: a 64x16 register file with one synchronous write port and one combinational read port. It is instantiated once for rows.
- `mv_buf` is 63x2 flops held inline.

## Test plan
- Reset with `rst` = 1 for 1 cycle → `out_valid` = 0, `out` = 0, `err` = 0 on the next edge.
- Full frame, `guy` = 5, all rows 0, solver model writes 63 stops and pulses `slv_done` 10 cycles after `slv_start` → `slv_pos` = 5; `slv_rdata` at addr 8 = 0x0000; exactly 63 `out_valid` cycles, all `out` = 0; `out_valid` rises 1 cycle after `slv_done`.
- Row 8 = lane7 code 1, others 3 → `slv_rdata`[addr 8] = 0x7FFF. Solver writes move 7 = 3 (jump) → 8th drained `out` = 3.
- Solver never pulses `slv_done`, `LAT_MAX` = 50 → `err` = 1, burst starts 51 cycles after `slv_start`, 63 zeros.
- `rst` pulsed at the 20th drain cycle → `out_valid` = 0 and `out` = 0 on the next edge, FSM in IDLE; the next frame completes normally.
- `in_valid` held for only 40 rows → `err` = 1, rows 40..63 read as 0, burst still exactly 63 cycles.

Source files
------------

// File: rtl/guy_pkg.sv
// guy_pkg: shared codes, sizes and FSM states for the lane-runner frame sequencer
package guy_pkg;
  localparam int N_ROWS = 64;
  localparam int N_MOVES = 63;
  localparam int N_LANES = 8;
  typedef enum logic [1:0] {MV_STOP, MV_RIGHT, MV_LEFT, MV_JUMP} move_t;
  typedef enum logic [1:0] {OB_FREE, OB_LOW, OB_HIGH, OB_WALL} obst_t;
  typedef enum logic [1:0] {IDLE, LOAD, SOLVE, DRAIN} state_t;
endpackage

// File: rtl/guy_row_buf.sv
// guy_row_buf: 64x16 row register file, synchronous write, combinational read
module guy_row_buf
  import guy_pkg::*;
(
  input  logic                   clk,
  input  logic                   we,
  input  logic [5:0]             waddr,
  input  logic [2*N_LANES-1:0]   wdata,
  input  logic [5:0]             raddr,
  output logic [2*N_LANES-1:0]   rdata
);
  logic [2*N_LANES-1:0] mem [N_ROWS];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/guy_frame_ctrl.sv
// guy_frame_ctrl: captures a 64-row frame, hosts the move solver and drains 63 moves as one burst
module guy_frame_ctrl
  import guy_pkg::*;
#(
  parameter int LAT_MAX = 2900
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [2:0]  guy,
  input  logic [1:0]  in0,
  input  logic [1:0]  in1,
  input  logic [1:0]  in2,
  input  logic [1:0]  in3,
  input  logic [1:0]  in4,
  input  logic [1:0]  in5,
  input  logic [1:0]  in6,
  input  logic [1:0]  in7,
  output logic        slv_start,
  output logic [2:0]  slv_pos,
  input  logic [5:0]  slv_raddr,
  output logic [15:0] slv_rdata,
  input  logic        slv_we,
  input  logic [5:0]  slv_waddr,
  input  logic [1:0]  slv_wdata,
  input  logic        slv_done,
  output logic        out_valid,
  output logic [1:0]  out,
  output logic        err
);
  localparam logic [11:0] LAT_LIM = 12'(LAT_MAX);
  state_t state, nxt;
  logic [5:0] cnt, cnt_nxt, fill, row_waddr;
  logic [11:0] lat;
  logic short_fill, row_we, mv_we, timeout, drop, err_set;
  logic [15:0] row_rd;
  logic [1:0] out_nxt;
  logic [1:0] mv_buf [N_MOVES];
  assign row_we = in_valid && (state == IDLE || state == LOAD);
  assign row_waddr = state == IDLE ? 6'd0 : cnt;
  assign drop = state == LOAD && !in_valid;
  assign mv_we = state == SOLVE && slv_we && slv_waddr != 6'd63;
  assign timeout = state == SOLVE && lat >= LAT_LIM;
  assign err_set = drop || (timeout && !slv_done) ||
                   (state == SOLVE && slv_we && slv_waddr == 6'd63) ||
                   (in_valid && (state == SOLVE || state == DRAIN));
  guy_row_buf u_rows (
    .clk,
    .we(row_we),
    .waddr(row_waddr),
    .wdata({in7, in6, in5, in4, in3, in2, in1, in0}),
    .raddr(slv_raddr),
    .rdata(row_rd)
  );
  // rows past a truncated frame read as zero until a later frame rewrites them
  assign slv_rdata = short_fill && slv_raddr >= fill ? 16'h0 : row_rd;
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    case (state)
      IDLE:    if (in_valid) begin nxt = LOAD; cnt_nxt = 6'd1; end
      LOAD:    if (!in_valid || cnt == 6'd63) nxt = SOLVE; else cnt_nxt = cnt + 6'd1;
      SOLVE:   if (slv_done || timeout) begin nxt = DRAIN; cnt_nxt = 6'd0; end
      DRAIN:   if (cnt == 6'd62) nxt = IDLE; else cnt_nxt = cnt + 6'd1;
      default: nxt = IDLE;
    endcase
    // a move written in the done cycle must already be visible to the first drained slot
    out_nxt = nxt != DRAIN ? MV_STOP :
              mv_we && slv_waddr == cnt_nxt ? slv_wdata : mv_buf[cnt_nxt];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      lat <= '0;
      slv_pos <= '0;
      slv_start <= 1'b0;
      err <= 1'b0;
      out_valid <= 1'b0;
      out <= '0;
      short_fill <= 1'b0;
      fill <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      slv_start <= state == LOAD && nxt == SOLVE;
      out_valid <= nxt == DRAIN;
      out <= out_nxt;
      lat <= state != SOLVE ? 12'd0 : lat + {11'd0, lat != 12'hFFF};
      if (state == IDLE && in_valid) begin
        slv_pos <= guy;
        err <= 1'b0;
      end else if (err_set) err <= 1'b1;
      if (drop) begin
        short_fill <= 1'b1;
        fill <= cnt;
      end else if (short_fill && row_we && row_waddr == fill) begin
        if (fill == 6'd63) short_fill <= 1'b0;
        else fill <= fill + 6'd1;
      end
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < N_MOVES; i++)
      if (state == IDLE && in_valid) mv_buf[i] <= MV_STOP;
      else if (mv_we && slv_waddr == 6'(i)) mv_buf[i] <= slv_wdata;
endmodule
